// File: rtl/usb_tx_encoder.sv
// USB full-speed bit-level transmitter: SYNC, LSB-first data with bit stuffing, NRZI onto D+/D-, EOP.
// Optional USB_TX_UNDERRUN_EN adds a tx_underrun pulse output on a mid-packet byte underrun.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy
`ifdef USB_TX_UNDERRUN_EN
  ,
  output logic       tx_underrun
`endif
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          last_q, last_d;
  logic [2:0]    ones_q, ones_d;
  logic          end_q, end_d;
  logic          dp_q, dp_d;
  logic          dm_q, dm_d;
  logic          busy_q, busy_d;

  logic boundary, load_slot, emit, emit_bit, more;

  assign boundary  = (timer_q == TMAX);
  // Final bit period of a non-last byte: the only mid-packet point where a byte is taken.
  assign load_slot = (state_q == DATA) && boundary && (bit_cnt_q == 3'd7) && !last_q;
  assign in_ready  = n_rst && ((state_q == IDLE) || load_slot);
  assign d_plus    = dp_q;
  assign d_minus   = dm_q;
  assign tx_busy   = busy_q;
`ifdef USB_TX_UNDERRUN_EN
  assign tx_underrun = n_rst && load_slot && !in_valid;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    last_d    = last_q;
    ones_d    = ones_q;
    end_d     = end_q;
    dp_d      = dp_q;
    dm_d      = dm_q;
    busy_d    = busy_q;
    emit      = 1'b0;
    emit_bit  = 1'b0;
    more      = 1'b0;
    timer_d   = (state_q == IDLE || boundary) ? '0 : timer_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d   = SYNC;
          shift_d   = in_data;
          last_d    = in_last;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          emit      = 1'b1;
          emit_bit  = 1'b0;
        end
      end
      SYNC: begin
        if (boundary) begin
          emit = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            emit_bit  = shift_q[0];
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            emit_bit  = (bit_cnt_q == 3'd6);
          end
        end
      end
      DATA: begin
        if (boundary) begin
          if (bit_cnt_q != 3'd7) begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            more      = 1'b1;
          end else if (!last_q && in_valid) begin
            shift_d   = in_data;
            last_d    = in_last;
            bit_cnt_d = '0;
            more      = 1'b1;
          end
          // A pending stuff bit always goes out first; end_q remembers where to go after it.
          if (ones_q == 3'd6) begin
            state_d = STUFF;
            end_d   = !more;
            emit    = 1'b1;
          end else if (more) begin
            emit     = 1'b1;
            emit_bit = shift_d[0];
          end else begin
            state_d   = EOP_SE0;
            bit_cnt_d = '0;
            dp_d      = 1'b0;
            dm_d      = 1'b0;
          end
        end
      end
      STUFF: begin
        if (boundary) begin
          if (end_q) begin
            state_d   = EOP_SE0;
            bit_cnt_d = '0;
            dp_d      = 1'b0;
            dm_d      = 1'b0;
          end else begin
            state_d  = DATA;
            emit     = 1'b1;
            emit_bit = shift_q[0];
          end
        end
      end
      EOP_SE0: begin
        if (boundary) begin
          if (bit_cnt_q == 3'd1) begin
            state_d = EOP_J;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      EOP_J: begin
        if (boundary) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // NRZI: a 0 toggles J<->K and breaks the run of ones; a 1 holds the line.
    if (emit) begin
      if (emit_bit) begin
        ones_d = ones_q + 3'd1;
      end else begin
        ones_d = '0;
        dp_d   = ~dp_q;
        dm_d   = dp_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      last_q    <= 1'b0;
      ones_q    <= '0;
      end_q     <= 1'b0;
      dp_q      <= 1'b1;
      dm_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      ones_q    <= ones_d;
      end_q     <= end_d;
      dp_q      <= dp_d;
      dm_q      <= dm_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: line symbols sampled mid-bit against hand-derived J/K/SE0 strings.
module tb_usb_tx_encoder;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready, d_plus, d_minus, tx_busy;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         urun_n = 0;
`ifdef USB_TX_UNDERRUN_EN
  logic       tx_underrun;
`endif

  always #5 clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(8)) dut (
    .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .d_plus(d_plus), .d_minus(d_minus), .tx_busy(tx_busy)
`ifdef USB_TX_UNDERRUN_EN
    , .tx_underrun(tx_underrun)
`endif
  );

  function automatic string sym();
    case ({d_plus, d_minus})
      2'b10:   return "J";
      2'b01:   return "K";
      2'b00:   return "0";
      default: return "X";
    endcase
  endfunction

  // Sends one packet (optionally a second byte offered during the load slot) and records
  // the mid-bit line symbols, busy length, first in_ready cycle and in_ready cycle count.
  task automatic send_pkt(input logic [7:0] b0, input logic l0, input bit has_next,
                          input logic [7:0] b1, input logic l1, output string line,
                          output int busy_len, output int rdy_c, output int rdy_n);
    int  c;
    bit  hs;
    in_data = b0; in_last = l0; in_valid = 1'b1;
    @(posedge clk); #1;
    if (has_next) begin
      in_data = b1; in_last = l1;
    end else begin
      in_valid = 1'b0;
    end
    c = 0; line = ""; busy_len = -1; rdy_c = -1; rdy_n = 0; urun_n = 0;
    while (c <= 400) begin
      if (c % 8 == 4) line = {line, sym()};
      if (!tx_busy) begin
        busy_len = c;
        break;
      end
      if (in_ready) begin
        if (rdy_c < 0) rdy_c = c;
        rdy_n++;
      end
`ifdef USB_TX_UNDERRUN_EN
      if (tx_underrun) urun_n++;
`endif
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) in_valid = 1'b0;
      c++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit line_ok;
    n_rst = 1'b0; in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({d_plus, d_minus, tx_busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_line: got dp/dm/busy=%b want 100", {d_plus, d_minus, tx_busy});
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0", in_ready);
    end
    in_valid = 1'b0; n_rst = 1'b1;
    line_ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if ({d_plus, d_minus, tx_busy} !== 3'b100) line_ok = 1'b0;
    end
    n_cmp++;
    if (!line_ok) begin
      n_bad++;
      $display("FAIL idle_after_reset: got line not J/idle want J/idle");
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    string line; int bl, rc, rn;
    send_pkt(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, line, bl, rc, rn);
    n_cmp++;
    if (line != "KJKJKJKKJKJKJKJK00J") begin
      n_bad++; $display("FAIL single_line: got %s want KJKJKJKKJKJKJKJK00J", line);
    end
    n_cmp++;
    if (bl !== 152) begin n_bad++; $display("FAIL single_busy: got %0d want 152", bl); end
    n_cmp++;
    if (rn !== 0) begin n_bad++; $display("FAIL single_ready: got %0d want 0", rn); end
  endtask

  task automatic test_stuffing();
    string line; int bl, rc, rn;
    send_pkt(8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, line, bl, rc, rn);
    n_cmp++;
    if (line != "KJKJKJKKKKKKKJJJJ00J") begin
      n_bad++; $display("FAIL stuff_line: got %s want KJKJKJKKKKKKKJJJJ00J", line);
    end
    n_cmp++;
    if (bl !== 160) begin n_bad++; $display("FAIL stuff_busy: got %0d want 160", bl); end
  endtask

  task automatic test_stuff_before_eop();
    string line; int bl, rc, rn;
    send_pkt(8'hFC, 1'b1, 1'b0, 8'h00, 1'b0, line, bl, rc, rn);
    n_cmp++;
    if (line != "KJKJKJKKJKKKKKKKJ00J") begin
      n_bad++; $display("FAIL stuff_eop_line: got %s want KJKJKJKKJKKKKKKKJ00J", line);
    end
    n_cmp++;
    if (bl !== 160) begin n_bad++; $display("FAIL stuff_eop_busy: got %0d want 160", bl); end
  endtask

  task automatic test_back_to_back();
    string line; int bl, rc, rn;
    send_pkt(8'hA5, 1'b0, 1'b1, 8'h3C, 1'b1, line, bl, rc, rn);
    n_cmp++;
    if (line != "KJKJKJKKKJJKJJKKJKKKKKJK00J") begin
      n_bad++; $display("FAIL b2b_line: got %s want KJKJKJKKKJJKJJKKJKKKKKJK00J", line);
    end
    n_cmp++;
    if (bl !== 216) begin n_bad++; $display("FAIL b2b_busy: got %0d want 216", bl); end
    n_cmp++;
    if (rc !== 127 || rn !== 1) begin
      n_bad++; $display("FAIL b2b_ready: got cycle %0d count %0d want cycle 127 count 1", rc, rn);
    end
  endtask

  task automatic test_underrun();
    string line; int bl, rc, rn;
    send_pkt(8'h12, 1'b0, 1'b0, 8'h00, 1'b0, line, bl, rc, rn);
    n_cmp++;
    if (line != "KJKJKJKKJJKJJKJK00J") begin
      n_bad++; $display("FAIL underrun_line: got %s want KJKJKJKKJJKJJKJK00J", line);
    end
    n_cmp++;
    if (bl !== 152) begin n_bad++; $display("FAIL underrun_busy: got %0d want 152", bl); end
    n_cmp++;
    if (rc !== 127 || rn !== 1) begin
      n_bad++; $display("FAIL underrun_ready: got cycle %0d count %0d want cycle 127 count 1", rc, rn);
    end
`ifdef USB_TX_UNDERRUN_EN
    n_cmp++;
    if (urun_n !== 1) begin n_bad++; $display("FAIL underrun_pulse: got %0d want 1", urun_n); end
`endif
  endtask

  task automatic test_mid_reset();
    string line; int bl, rc, rn, n_hs;
    bit hs;
    in_data = 8'h11; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'h22;
    n_hs = 0;
    for (int c = 0; c < 140; c++) begin
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        n_hs++;
        in_data = 8'h33; in_last = 1'b1;
      end
    end
    n_cmp++;
    if (n_hs !== 1 || tx_busy !== 1'b1) begin
      n_bad++; $display("FAIL midrst_setup: got handshakes %0d busy %b want 1 1", n_hs, tx_busy);
    end
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({d_plus, d_minus, tx_busy, in_ready} !== 4'b1000) begin
      n_bad++;
      $display("FAIL midrst_abort: got dp/dm/busy/rdy=%b want 1000", {d_plus, d_minus, tx_busy, in_ready});
    end
    @(posedge clk); #1;
    n_rst = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({d_plus, d_minus, tx_busy} !== 3'b100) begin
      n_bad++; $display("FAIL midrst_idle: got dp/dm/busy=%b want 100", {d_plus, d_minus, tx_busy});
    end
    send_pkt(8'hFC, 1'b1, 1'b0, 8'h00, 1'b0, line, bl, rc, rn);
    n_cmp++;
    if (line != "KJKJKJKKJKKKKKKKJ00J" || bl !== 160) begin
      n_bad++; $display("FAIL midrst_restart: got %s busy %0d want KJKJKJKKJKKKKKKKJ00J busy 160", line, bl);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stuffing();
    test_stuff_before_eop();
    test_back_to_back();
    test_underrun();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
